key_debounce_multi: RTL and testbench



---
 rtl/key_pkg.sv | 31 +++
 rtl/key_debounce_ch.sv | 132 +++++++++++++
 rtl/key_debounce_multi.sv | 47 ++++
 tb/tb_key_debounce_multi.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning bank.
// Provides cycle-count helpers, counter width helper and key_evt_t.
package key_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;

  function automatic int unsigned ms_to_cycles(
    input int unsigned clk_hz,
    input int unsigned ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

  // Width of a counter that must hold values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEB_20MS_50M =
    ms_to_cycles(CLK_HZ_DEF, 20);
  localparam int unsigned LONG_1S_50M =
    ms_to_cycles(CLK_HZ_DEF, 1000);

  typedef struct packed {
    logic state;
    logic press;
    logic rel;
    logic long_p;
  } key_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF sync, debounce, edge pulses, long-press/repeat.
// Ports: clk, rst_n (async low), key_in (raw pin), evt_o (key_evt_t).
// Repeat pulses built only with KEY_DEBOUNCE_MULTI_REPEAT_EN defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CNT        = 1_000_000,
  parameter int LONG_CNT       = 50_000_000,
  parameter int REPEAT_CNT     = 10_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_in,
  output key_evt_t evt_o
);

  if (DEB_CNT < 2 || LONG_CNT < 2 || REPEAT_CNT < 1)
  begin : g_bad_cfg
    $error("key_debounce_ch: bad count parameter");
  end

  localparam int DW = cnt_w(DEB_CNT);
  localparam int LW = cnt_w(LONG_CNT);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CNT - 1);
  localparam logic [LW-1:0] HOLD_ARM  = LW'(LONG_CNT - 2);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [LW-1:0] hold_q, hold_d;

`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_CNT);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    s1_d    = key_in ^ KEY_ACTIVE_LOW;
    s2_d    = s1_q;
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;

    if (s2_q == state_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_LAST) begin
      state_d = s2_q;
      deb_d   = '0;
      press_d = s2_q;
      rel_d   = ~s2_q;
    end else begin
      deb_d = deb_q + DW'(1);
    end

    // Held count starts the cycle after the press commits and
    // saturates, so the first long pulse lands at press+LONG_CNT-1.
    if (!state_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + LW'(1);
    end

    if (state_q && state_d && hold_q == HOLD_ARM) begin
      long_d = 1'b1;
    end

`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    rep_d = rep_q;
    if (!state_q) begin
      rep_d = '0;
    end else if (hold_q == HOLD_LAST) begin
      if (rep_q == REP_LAST) begin
        rep_d  = '0;
        long_d = state_d;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      deb_q   <= '0;
      hold_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
    end
  end

`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign evt_o = '{
    state:  state_q,
    press:  press_q,
    rel:    rel_q,
    long_p: long_q
  };

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: debounced level, press/release, long pulses.
// Ports: sys_clk, sys_rst_n, key_in[N], key_state/press/release/long[N].
// Auto-repeat on key_long enabled by KEY_DEBOUNCE_MULTI_REPEAT_EN.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEB_CNT        = 1_000_000,
  parameter int LONG_CNT       = 50_000_000,
  parameter int REPEAT_CNT     = 10_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_nk
    $error("key_debounce_multi: NUM_KEYS out of range");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_evt_t evt;

    key_debounce_ch #(
      .DEB_CNT        (DEB_CNT),
      .LONG_CNT       (LONG_CNT),
      .REPEAT_CNT     (REPEAT_CNT),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .key_in (key_in[i]),
      .evt_o  (evt)
    );

    assign key_state[i]   = evt.state;
    assign key_press[i]   = evt.press;
    assign key_release[i] = evt.rel;
    assign key_long[i]    = evt.long_p;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi (DEB 8, LONG 32, REPEAT 16).
// Stimulus queues timed events; a negedge monitor checks every cycle.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int EV_P = 0;
  localparam int EV_R = 1;
  localparam int EV_L = 2;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t           exp_q[$];
  logic [NK-1:0] exp_state;
  int            cyc;
  int            n_cmp;
  int            n_bad;

  key_debounce_multi #(
    .NUM_KEYS       (NK),
    .DEB_CNT        (8),
    .LONG_CNT       (32),
    .REPEAT_CNT     (16),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic pressed);
    key_in[ch] = ~pressed;
  endtask

  task automatic expect_ev(input int dc, input int ch, input int kind);
    ev_t e;
    int  i;
    e.cyc  = cyc + dc;
    e.ch   = ch;
    e.kind = kind;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= e.cyc) i++;
    exp_q.insert(i, e);
  endtask

  initial exp_state = '0;

  always @(negedge clk) begin
    logic [NK-1:0] ep, er, el;
    ev_t           e;
    ep = '0;
    er = '0;
    el = '0;
    if (!rst_n) begin
      exp_state = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missed_event ch%0d kind%0d got none want at cyc %0d",
                   e.ch, e.kind, e.cyc);
        end else begin
          case (e.kind)
            EV_P: begin ep[e.ch] = 1'b1; exp_state[e.ch] = 1'b1; end
            EV_R: begin er[e.ch] = 1'b1; exp_state[e.ch] = 1'b0; end
            default: el[e.ch] = 1'b1;
          endcase
        end
      end
    end
    n_cmp++;
    if ({key_state, key_press, key_release, key_long} !==
        {exp_state, ep, er, el}) begin
      n_bad++;
      $display("FAIL outputs cyc%0d got st=%b pr=%b rl=%b lg=%b want st=%b pr=%b rl=%b lg=%b",
               cyc, key_state, key_press, key_release, key_long,
               exp_state, ep, er, el);
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    key_in = '1;
    step(3);
    rst_n = 1'b1;
    step(3);

    // clean press then release of ch0, released before long
    drive(0, 1'b1);
    expect_ev(10, 0, EV_P);
    step(15);
    drive(0, 1'b0);
    expect_ev(10, 0, EV_R);
    step(15);

    // ch1 bounces, then settles pressed
    for (int r = 0; r < 4; r++) begin
      drive(1, 1'b1);
      step(5);
      drive(1, 1'b0);
      step(2);
    end
    drive(1, 1'b1);
    expect_ev(10, 1, EV_P);
    step(15);
    drive(1, 1'b0);
    expect_ev(10, 1, EV_R);
    step(15);

    // ch2 long press
    drive(2, 1'b1);
    expect_ev(10, 2, EV_P);
    expect_ev(41, 2, EV_L);
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    expect_ev(57, 2, EV_L);
`endif
    step(50);
    drive(2, 1'b0);
    expect_ev(10, 2, EV_R);
    step(15);

    // simultaneous channel events
    drive(0, 1'b1);
    drive(3, 1'b1);
    expect_ev(10, 0, EV_P);
    expect_ev(10, 3, EV_P);
    step(12);
    drive(0, 1'b0);
    drive(1, 1'b1);
    expect_ev(10, 0, EV_R);
    expect_ev(10, 1, EV_P);
    step(8);
    drive(3, 1'b0);
    drive(1, 1'b0);
    expect_ev(10, 3, EV_R);
    expect_ev(10, 1, EV_R);
    step(15);

    // async reset while ch2 is held
    drive(2, 1'b1);
    expect_ev(10, 2, EV_P);
    step(20);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({key_state, key_press, key_release, key_long} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got st=%b pr=%b rl=%b lg=%b want all 0",
               key_state, key_press, key_release, key_long);
    end
    step(3);
    rst_n = 1'b1;
    expect_ev(10, 2, EV_P);
    step(15);
    drive(2, 1'b0);
    expect_ev(10, 2, EV_R);
    step(15);

    // ch0 held 80 cycles after press
    drive(0, 1'b1);
    expect_ev(10, 0, EV_P);
    expect_ev(41, 0, EV_L);
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    expect_ev(57, 0, EV_L);
    expect_ev(73, 0, EV_L);
    expect_ev(89, 0, EV_L);
`endif
    step(90);
    drive(0, 1'b0);
    expect_ev(10, 0, EV_R);
    step(15);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
